// File: rtl/instr_fetch_decode.sv
// MIPS fetch/decode stage: owns the PC, handshakes with instruction memory and
// registers the decoded R/I-type fields. Optional fetch timeout: FETCH_TIMEOUT_EN.
module instr_fetch_decode #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_RETRY
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic        imem_req_reg;
  logic        instr_valid_reg;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_reg;
  logic          fetch_err_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      pc_reg          <= RESET_PC;
      ir_reg          <= '0;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_reg         <= '0;
      fetch_err_reg   <= 1'b0;
`endif
    end else begin
`ifdef FETCH_TIMEOUT_EN
      fetch_err_reg <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          state_reg    <= S_REQ;
          imem_req_reg <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          cnt_reg      <= '0;
`endif
        end
        S_REQ: begin
          // an ack on the timeout cycle still wins over the error
          if (imem_ack) begin
            ir_reg          <= imem_rdata;
            instr_valid_reg <= 1'b1;
            imem_req_reg    <= 1'b0;
            state_reg       <= S_ISSUE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_reg == TO_LAST) begin
            fetch_err_reg <= 1'b1;
            imem_req_reg  <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= S_RETRY;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        S_ISSUE: begin
          if (!stall) begin
            pc_reg          <= branch_taken ? (branch_target & 32'hFFFF_FFFC)
                                            : pc_reg + 32'd4;
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b1;
            state_reg       <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
            cnt_reg         <= '0;
`endif
          end
        end
        S_RETRY: begin
          state_reg    <= S_REQ;
          imem_req_reg <= 1'b1;
        end
        default: begin
          state_reg    <= S_IDLE;
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign pc_out      = pc_reg;
  assign instr_valid = instr_valid_reg;

  // fields are slices of the instruction register, so they only move on an IR load
  assign opcode = ir_reg[31:26];
  assign rs     = ir_reg[25:21];
  assign rt     = ir_reg[20:16];
  assign rd     = ir_reg[15:11];
  assign shamt  = ir_reg[10:6];
  assign funct  = ir_reg[5:0];
  assign imm16  = ir_reg[15:0];

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = fetch_err_reg;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: handshake, decode, stall/branch,
// PC wrap (second instance), mid-fetch reset and the fetch timeout path.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ack, stall, br;
  logic [31:0] rdata, bt;
  logic        req, valid, ferr;
  logic [31:0] addr, pc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  logic        w_ack;
  logic        w_req, w_valid, w_ferr;
  logic [31:0] w_addr, w_pc;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch_decode #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(req), .imem_addr(addr),
    .imem_rdata(rdata), .imem_ack(ack), .stall(stall),
    .branch_taken(br), .branch_target(bt), .pc_out(pc),
    .instr_valid(valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm16(imm), .fetch_err(ferr)
  );

  instr_fetch_decode #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(32'h2001_0001), .imem_ack(w_ack), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0), .pc_out(w_pc),
    .instr_valid(w_valid), .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd),
    .shamt(w_shamt), .funct(w_funct), .imm16(w_imm), .fetch_err(w_ferr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0; stall = 1'b0; br = 1'b0;
    rdata = 32'h0; bt = 32'h0; w_ack = 1'b1;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_opcode", opcode, 6'h0);
    chk("rst_w_pc", w_pc, 32'hFFFF_FFFC);

    rst_n = 1'b1;
    chk("idle_req", req, 1'b0);
    tick();
    chk("req_rise", req, 1'b1);
    chk("req_addr", addr, 32'h0);
    chk("w_req_addr", w_addr, 32'hFFFF_FFFC);
    tick();
    chk("wait1_req", req, 1'b1);
    chk("wait1_valid", valid, 1'b0);
    chk("w_issue_valid", w_valid, 1'b1);
    tick();
    chk("w_pc_wrap", w_pc, 32'h0);
    w_ack = 1'b0;
    ack = 1'b1; rdata = 32'h2001_FFFF;
    tick();
    ack = 1'b0;
    chk("i_valid", valid, 1'b1);
    chk("i_opcode", opcode, 6'h08);
    chk("i_rs", rs, 5'd0);
    chk("i_rt", rt, 5'd1);
    chk("i_imm", imm, 16'hFFFF);
    chk("i_req_low", req, 1'b0);
    chk("i_pc", pc, 32'h0);
    tick();
    chk("retire_pc", pc, 32'h4);
    chk("retire_valid", valid, 1'b0);
    chk("retire_req", req, 1'b1);
    chk("retire_addr", addr, 32'h4);
    chk("hold_fields", opcode, 6'h08);

    ack = 1'b1; rdata = 32'h0022_1820;
    tick();
    stall = 1'b1; br = 1'b1; bt = 32'h0000_0103;
    rdata = 32'hFFFF_FFFF;
    chk("r_opcode", opcode, 6'h00);
    chk("r_rs", rs, 5'd1);
    chk("r_rt", rt, 5'd2);
    chk("r_rd", rd, 5'd3);
    chk("r_shamt", shamt, 5'd0);
    chk("r_funct", funct, 6'h20);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc", pc, 32'h4);
      chk("stall_valid", valid, 1'b1);
      chk("stall_req", req, 1'b0);
      chk("stall_rd", rd, 5'd3);
      chk("stall_funct", funct, 6'h20);
    end
    ack = 1'b0; stall = 1'b0;
    tick();
    chk("br_pc", pc, 32'h0000_0100);
    chk("br_addr", addr, 32'h0000_0100);
    chk("br_req", req, 1'b1);
    chk("br_valid", valid, 1'b0);
    br = 1'b0;

    ack = 1'b1; rdata = 32'h8C43_0004;
    tick();
    ack = 1'b0;
    chk("lw_valid", valid, 1'b1);
    chk("lw_opcode", opcode, 6'h23);
    chk("lw_rs", rs, 5'd2);
    chk("lw_rt", rt, 5'd3);
    chk("lw_imm", imm, 16'h0004);
    tick();
    chk("seq_pc", pc, 32'h0000_0104);
    chk("seq_req", req, 1'b1);

    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_req", req, 1'b0);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_opcode", opcode, 6'h0);
    chk("mid_rst_w_pc", w_pc, 32'hFFFF_FFFC);
    ack = 1'b1; rdata = 32'h1234_5678;
    tick();
    rst_n = 1'b1;
    chk("post_rst_idle_req", req, 1'b0);
    tick();
    ack = 1'b0;
    chk("post_rst_ack_ignored", valid, 1'b0);
    chk("post_rst_req", req, 1'b1);

`ifdef FETCH_TIMEOUT_EN
    begin
      int hi = 1;
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        tick();
        if (req) hi++;
        else seen = 1'b1;
      end
      chk("to_seen", seen, 1'b1);
      chk("to_req_cycles", hi, 16);
      chk("to_ferr", ferr, 1'b1);
      chk("to_req_low", req, 1'b0);
      tick();
      chk("to_ferr_pulse", ferr, 1'b0);
      chk("to_rereq", req, 1'b1);
      chk("to_addr", addr, 32'h0);
    end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("noto_ferr", ferr, 1'b0);
      chk("noto_req", req, 1'b1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Fetch/decode stage directly upstream of the immediate sign-extension stage in the MIPS single-cycle datapath.
- Owns the PC and runs a request/acknowledge handshake with instruction memory.
- Captures each returned word into an instruction register and splits it into registered R/I-type fields.
- imm16 feeds the sign-extension stage; rs/rt/rd feed the register file; opcode/funct feed control.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 16, REQ-state cycles without ack before timeout (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, equals pc_out while imem_req=1
imem_rdata  input  32  instruction word, valid when imem_ack=1
imem_ack  input  1  memory response strobe
stall  input  1  downstream not ready; hold current instruction
branch_taken  input  1  redirect PC; sampled only on instruction retire
branch_target  input  32  redirect address; bits [1:0] forced to 0
pc_out  output  32  address of the instruction currently held or being fetched
instr_valid  output  1  decoded fields are valid
opcode  output  6  IR[31:26]
rs  output  5  IR[25:21]
rt  output  5  IR[20:16]
rd  output  5  IR[15:11]
shamt  output  5  IR[10:6]
funct  output  6  IR[5:0]
imm16  output  16  IR[15:0], to sign-extension stage
fetch_err  output  1  fetch timeout pulse

Behaviour:
- Reset (async, rst_n=0):
  - pc_out=RESET_PC; IR, all field outputs, imem_req, instr_valid and fetch_err = 0; state=IDLE.
  - imem_addr = pc_out at all times.
- State IDLE:
  - One cycle after reset release. Next state REQ.
- State REQ:
  - imem_req=1.
  - On a cycle with imem_ack=1: register imem_rdata into IR and all fields at that edge, set instr_valid=1, go to ISSUE.
  - Fields are visible the cycle after ack. Best-case latency: req rise to instr_valid = 1 cycle with same-cycle ack.
  - imem_ack while imem_req=0 is ignored.
- State ISSUE:
  - imem_req=0; instr_valid=1; fields held stable.
  - If stall=1: hold everything, ignore branch_taken.
  - If stall=0 (retire):
    - pc_out <= branch_taken ? {branch_target[31:2],2'b00} : pc_out+4.
    - instr_valid <= 0; next state REQ.
- Next-fetch timing: next imem_req rises the cycle after retire, so sustained throughput is one instruction per 2 cycles with zero-wait memory.
- Arithmetic: pc increment is modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0.
- Field outputs change only on IR load. They keep the last instruction while instr_valid=0.
- Reset mid-operation: async clear of all state regardless of FSM state. An outstanding memory ack after reset is ignored until REQ.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A cycle counter runs while in REQ and clears on entering REQ.
  - When it reaches TIMEOUT_CYCLES with no ack: fetch_err=1 for one cycle, imem_req=0 for that cycle, counter cleared, then the same pc_out is re-requested.
  - An ack in the same cycle the count is reached wins; no error is raised.
- Undefined: no counter; REQ waits indefinitely; fetch_err tied 0.

Test Plan:
- Reset: hold rst_n=0 then release -> pc_out=0, instr_valid=0, imem_req=0 in IDLE cycle, imem_req=1 on the next cycle with imem_addr=0.
- I-type with ack 2 cycles late: 32'h2001FFFF -> cycle after ack: instr_valid=1, opcode=6'h08, rs=0, rt=1, imm16=16'hFFFF. Retire with stall=0 -> pc_out=4.
- R-type 32'h00221820 -> rs=1, rt=2, rd=3, shamt=0, funct=6'h20.
- stall=1 for 5 cycles in ISSUE with branch_taken=1 -> fields, pc_out and instr_valid unchanged; imem_req=0. Release stall with branch_taken=1, branch_target=32'h0000_0103 -> pc_out=32'h0000_0100, next imem_addr=0x100.
- PC wrap: RESET_PC=32'hFFFF_FFFC, one fetch retired -> pc_out=0.
- FETCH_TIMEOUT_EN defined, no ack, TIMEOUT_CYCLES=16 -> fetch_err 1-cycle pulse, imem_req low 1 cycle, re-request same address. Also assert rst_n=0 mid-REQ -> immediate return to reset values.
